branch_pc_unit: RTL

//  Program-counter sequencer that consumes the jump decision from the condition tester.

---
 rtl/branch_pc_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/branch_pc_unit.sv
// Program-counter sequencer: forwards jump conditions to the tester and redirects
// fetch on taken jumps, otherwise streams sequential addresses over valid/ready.
module branch_pc_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic [3:0]       br_cond_in,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [PC_W-1:0]  br_target,
  input  logic             br_rel,
  output logic [3:0]       cond,
  input  logic             br_taken,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [PC_W-1:0]  fetch_pc,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             fv_q, fv_d;
  logic             fl_q, fl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  target;
  logic             jump;

  assign cond   = br_cond_in;
  assign target = br_rel ? br_pc + br_target : br_target;
  assign jump   = br_valid & ~stall & br_taken;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fv_d    = fv_q;
    fl_d    = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        fv_d    = ~stall;
      end
      RUN: begin
        if (jump) begin
          // redirect wins over any handshake completing this edge
          state_d = FLUSH;
          pc_d    = target;
          fv_d    = 1'b0;
          fl_d    = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end else if (halt_req) begin
          state_d = HALT;
          fv_d    = 1'b0;
        end else if (stall) begin
          fv_d = 1'b0;
        end else begin
          fv_d = 1'b1;
          if (fv_q & fetch_ready) pc_d = pc_q + PC_W'(1);
        end
      end
      FLUSH: begin
        state_d = RUN;
        fv_d    = ~stall;
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
          fv_d    = ~stall;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fv_q    <= 1'b0;
      fl_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      fl_q    <= fl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_valid = fv_q;
  assign fetch_pc    = pc_q;
  assign flush       = fl_q;
  assign taken_cnt   = cnt_q;

endmodule
